rand_slot_sched: RTL and testbench

- Controller that sequences a random-access slot buffer: NREQ write requesters share one buffer write port, and a single reader drains slots.
- Keeps a per-slot occupancy bitmap.
- Picks write and read slots with a deterministic LFSR-seeded circular scan, so slot order is pseudo-random but reproducible.
- Drives address and enable lines to an external synchronous slot memory with one-cycle read latency.

---
 rtl/rand_slot_sched.sv | 166 ++++++++++++++++
 tb/tb_rand_slot_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_slot_sched.sv
// Random-slot buffer controller: round-robin writers and one reader share an external slot memory; slot choice comes from an LFSR-seeded circular scan.
// Define RAND_SLOT_SCHED_STATS_EN to add the stall_cnt and gnt_cnt statistics outputs.
module rand_slot_sched #(
   parameter int          DEPTH     = 32,
   parameter int          WIDTH     = 8,
   parameter int          NREQ      = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   input  logic                  rd_req,
   output logic                  rd_valid,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_waddr,
   output logic [WIDTH-1:0]      mem_wdata,
   output logic                  mem_re,
   output logic [AW-1:0]         mem_raddr,
   input  logic [WIDTH-1:0]      mem_rdata,
   output logic [AW:0]           occupancy,
   output logic                  empty,
   output logic                  full
`ifdef RAND_SLOT_SCHED_STATS_EN
   ,
   output logic [15:0]           stall_cnt,
   output logic [NREQ*16-1:0]    gnt_cnt
`endif
);

   localparam int RW = $clog2(NREQ);

   logic [DEPTH-1:0] bitmap_q, bitmap_d;
   logic [AW:0]      occ_q, occ_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic [RW-1:0]    rr_q, rr_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             rd_valid_q;
   logic [WIDTH-1:0] rd_hold_q;

   logic [AW-1:0]    ws, rs;
   logic [AW-1:0]    wslot, rslot, widx, ridx;
   logic             arb_vld;
   logic [RW-1:0]    arb_idx, arb_try;
   logic             wr_fire, rd_fire;

   assign ws = lfsr_q[AW-1:0];
   assign rs = lfsr_q[15 -: AW];

   // Descending scan: the last hit written wins, i.e. the slot closest to the start index.
   always_comb begin
      wslot = '0;
      rslot = '0;
      widx  = '0;
      ridx  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         widx = ws + AW'(k);
         ridx = rs + AW'(k);
         if (!bitmap_q[widx]) wslot = widx;
         if (bitmap_q[ridx])  rslot = ridx;
      end
   end

   always_comb begin
      arb_vld = 1'b0;
      arb_idx = '0;
      arb_try = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         arb_try = RW'((int'(rr_q) + k) % NREQ);
         if (req[arb_try]) begin
            arb_vld = 1'b1;
            arb_idx = arb_try;
         end
      end
   end

   // Grant uses the registered full flag, so a read freeing a slot this cycle cannot admit a write.
   assign wr_fire = arb_vld && !full_q && !rst;
   assign rd_fire = rd_req && !empty_q && !rst;

   assign gnt       = wr_fire ? (NREQ'(1) << arb_idx) : '0;
   assign mem_we    = wr_fire;
   assign mem_waddr = wslot;
   assign mem_wdata = req_data[arb_idx*WIDTH +: WIDTH];
   assign mem_re    = rd_fire;
   assign mem_raddr = rslot;

   always_comb begin
      bitmap_d = bitmap_q;
      if (wr_fire) bitmap_d[wslot] = 1'b1;
      if (rd_fire) bitmap_d[rslot] = 1'b0;
   end

   always_comb begin
      occ_d = occ_q;
      case ({wr_fire, rd_fire})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase
      empty_d = (occ_d == '0);
      full_d  = (occ_d == (AW+1)'(DEPTH));
   end

   always_comb begin
      rr_d = rr_q;
      if (wr_fire) rr_d = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + RW'(1);
   end

   // Fibonacci LFSR, taps 16,14,13,11.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitmap_q   <= '0;
         occ_q      <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rr_q       <= '0;
         lfsr_q     <= LFSR_SEED;
         rd_valid_q <= 1'b0;
         rd_hold_q  <= '0;
      end else begin
         bitmap_q   <= bitmap_d;
         occ_q      <= occ_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rr_q       <= rr_d;
         lfsr_q     <= lfsr_d;
         rd_valid_q <= rd_fire;
         if (rd_valid_q) rd_hold_q <= mem_rdata;
      end
   end

   // Memory data arrives in the rd_valid cycle; pass it through then and hold it afterwards.
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_valid_q ? mem_rdata : rd_hold_q;
   assign occupancy = occ_q;
   assign empty     = empty_q;
   assign full      = full_q;

`ifdef RAND_SLOT_SCHED_STATS_EN
   logic [15:0]            stall_q;
   logic [NREQ-1:0][15:0]  gcnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         gcnt_q  <= '0;
      end else begin
         if ((|req) && full_q && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_q[i] <= gcnt_q[i] + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign gnt_cnt   = gcnt_q;
`endif

endmodule

// File: tb/tb_rand_slot_sched.sv
// Bench for rand_slot_sched: directed phases plus random traffic, checked against a slot-level reference model.
module tb_rand_slot_sched;
   localparam int DEPTH = 32;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int AW    = 5;
   localparam logic [15:0] SEED = 16'hACE1;

   logic                  clk, rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic                  rd_req, rd_valid;
   logic [WIDTH-1:0]      rd_data;
   logic                  mem_we, mem_re;
   logic [AW-1:0]         mem_waddr, mem_raddr;
   logic [WIDTH-1:0]      mem_wdata, mem_rdata;
   logic [AW:0]           occupancy;
   logic                  empty, full;
`ifdef RAND_SLOT_SCHED_STATS_EN
   logic [15:0]           stall_cnt;
   logic [NREQ*16-1:0]    gnt_cnt;
`endif

   rand_slot_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .occupancy(occupancy), .empty(empty), .full(full)
`ifdef RAND_SLOT_SCHED_STATS_EN
      , .stall_cnt(stall_cnt), .gnt_cnt(gnt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External slot memory with one-cycle read latency.
   logic [WIDTH-1:0] tb_mem [DEPTH];
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
      if (mem_re) mem_rdata <= tb_mem[mem_raddr];
   end

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   bit               m_bm [DEPTH];
   logic [WIDTH-1:0] m_dat [DEPTH];
   int               m_occ, m_rr;
   logic [15:0]      m_lfsr;
   bit               m_pend;
   logic [WIDTH-1:0] m_pend_dat, m_hold;

   // Observations from the last step
   logic [NREQ-1:0]  o_gnt;
   logic             o_we, o_re, o_rv;
   logic [AW-1:0]    o_waddr, o_raddr;
   logic [WIDTH-1:0] o_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_bm[i] = 1'b0;
      m_occ = 0; m_rr = 0; m_lfsr = SEED;
      m_pend = 1'b0; m_pend_dat = '0; m_hold = '0;
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_gnt", gnt, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_re", mem_re, 0);
   endtask

   // One clock cycle: predict from the model, compare at negedge, advance model at posedge.
   task automatic step();
      int g, ws, rs, wslot, rslot, s;
      logic wr, fire;
      logic [WIDTH-1:0] wdat;
      @(negedge clk);
      ws = int'(m_lfsr) % DEPTH;
      rs = int'(m_lfsr) >> (16 - AW);
      g = -1;
      if (m_occ < DEPTH)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      wr = (g >= 0);
      fire = rd_req && (m_occ > 0);
      wslot = -1; rslot = -1;
      for (int k = 0; k < DEPTH; k++) begin
         s = (ws + k) % DEPTH;
         if (wslot < 0 && !m_bm[s]) wslot = s;
         s = (rs + k) % DEPTH;
         if (rslot < 0 && m_bm[s]) rslot = s;
      end
      wdat = wr ? req_data[g*WIDTH +: WIDTH] : '0;
      check("gnt", gnt, wr ? (32'd1 << g) : 32'd0);
      check("mem_we", mem_we, wr);
      if (wr) begin
         check("mem_waddr", mem_waddr, wslot);
         check("mem_wdata", mem_wdata, wdat);
      end
      check("mem_re", mem_re, fire);
      if (fire) check("mem_raddr", mem_raddr, rslot);
      check("rd_valid", rd_valid, m_pend);
      check("rd_data", rd_data, m_pend ? m_pend_dat : m_hold);
      check("occupancy", occupancy, m_occ);
      check("empty", empty, m_occ == 0);
      check("full", full, m_occ == DEPTH);
      o_gnt = gnt; o_we = mem_we; o_re = mem_re; o_rv = rd_valid;
      o_waddr = mem_waddr; o_raddr = mem_raddr; o_rdata = rd_data;
      @(posedge clk);
      if (m_pend) m_hold = m_pend_dat;
      m_pend = fire;
      if (fire) begin
         m_pend_dat = m_dat[rslot];
         m_bm[rslot] = 1'b0;
      end
      if (wr) begin
         m_bm[wslot] = 1'b1;
         m_dat[wslot] = wdat;
         m_rr = (g + 1) % NREQ;
      end
      m_occ = m_occ + (wr ? 1 : 0) - (fire ? 1 : 0);
      m_lfsr = 16'(((m_lfsr << 1) | 16'(((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 16'd1)));
      #1;
   endtask

   initial begin
      int n, nv, distinct;
      int seen [DEPTH];
      int got [256];
      rst = 1'b1; req = '0; req_data = '0; rd_req = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Fill: all requesters, data value equals the grant number
      for (int i = 0; i < DEPTH; i++) seen[i] = 0;
      n = 0;
      req = 4'b1111;
      req_data = {4{8'(n)}};
      for (int c = 0; c < 34; c++) begin
         step();
         if (o_we) begin
            seen[o_waddr]++;
            n++;
            req_data = {4{8'(n)}};
         end
      end
      distinct = 0;
      for (int i = 0; i < DEPTH; i++) if (seen[i] == 1) distinct++;
      check("fill_grants", n, 32);
      check("fill_distinct_addr", distinct, 32);
      check("fill_full", full, 1);
      check("fill_gnt_zero", gnt, 0);

      // Drain: returned values must be a permutation of 0..31
      for (int i = 0; i < 256; i++) got[i] = 0;
      req = '0; rd_req = 1'b1; nv = 0;
      for (int c = 0; c < 34; c++) begin
         step();
         if (o_rv) begin
            got[o_rdata]++;
            nv++;
         end
      end
      distinct = 0;
      for (int i = 0; i < DEPTH; i++) if (got[i] == 1) distinct++;
      check("drain_valid_count", nv, 32);
      check("drain_permutation", distinct, 32);
      check("drain_empty", empty, 1);
      step();
      check("drain_no_re", o_re, 0);

      // Random traffic: requesters hold until granted
      rd_req = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req[i] && ($urandom_range(0, 99) < (c < 200 ? 50 : 10))) begin
               req[i] = 1'b1;
               req_data[i*WIDTH +: WIDTH] = 8'($urandom);
            end
         rd_req = ($urandom_range(0, 99) < (c < 200 ? 30 : 80));
         step();
         req = req & ~o_gnt;
      end

      // Simultaneous write and read at occupancy 10
      req = '0; rd_req = 1'b1;
      for (int c = 0; c < 64 && (m_occ != 0 || m_pend); c++) step();
      check("sim_pre_empty", empty, 1);
      rd_req = 1'b0; req = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         req_data = {4{8'($urandom)}};
         step();
      end
      check("sim_occ_before", occupancy, 10);
      req = 4'b0100; rd_req = 1'b1;
      step();
      check("sim_gnt", o_gnt, 4'b0100);
      check("sim_we", o_we, 1);
      check("sim_re", o_re, 1);
      check("sim_addr_differ", o_waddr != o_raddr, 1);
      req = '0; rd_req = 1'b0;
      check("sim_occ_after", occupancy, 10);

      // Full edge: read frees a slot but the grant waits a cycle
      req = 4'b0001;
      for (int c = 0; c < 40 && m_occ < DEPTH; c++) step();
      check("edge_full", full, 1);
      rd_req = 1'b1;
      step();
      check("edge_no_gnt", o_gnt, 0);
      check("edge_re", o_re, 1);
      rd_req = 1'b0;
      step();
      check("edge_gnt_next", o_gnt, 4'b0001);
      req = '0;
      check("edge_occ", occupancy, 32);

      // Reset with a read in flight and rr pointer away from 0
      rd_req = 1'b1;
      step();
      req = 4'b0001;
      step();
      rst = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      rd_req = 1'b0;
      req = 4'b1111;
      step();
      check("rst_rr_first_gnt", o_gnt, 4'b0001);
      req = 4'b0001;
      for (int c = 0; c < 40 && m_occ < DEPTH; c++) step();
      check("stats_fill_full", full, 1);
      req = 4'b0010;
      for (int c = 0; c < 5; c++) step();
      req = '0; rd_req = 1'b1;
      for (int c = 0; c < 3; c++) step();
      rd_req = 1'b0; req = 4'b0010;
      for (int c = 0; c < 3; c++) step();
      req = '0;
      step();
`ifdef RAND_SLOT_SCHED_STATS_EN
      check("stall_cnt", stall_cnt, 5);
      check("gnt_cnt0", gnt_cnt[15:0], 32);
      check("gnt_cnt1", gnt_cnt[31:16], 3);
      check("gnt_cnt2", gnt_cnt[47:32], 0);
`endif
      check("final_full", full, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
